// File: rtl/gga_field_parser_if.sv
// Received-byte stream from the UART RX side into the GGA field parser.
interface gga_field_parser_if;
  logic [7:0] uart_data;
  logic       uart_valid;

  modport master (output uart_data, output uart_valid);
  modport slave  (input  uart_data, input  uart_valid);
endinterface

// File: rtl/gga_field_parser.sv
// $GPGGA sentence parser: extracts time, latitude/hemisphere and longitude/hemisphere as BCD.
// Optional feature macro GGA_ERR_COUNT_EN builds the saturating error counter behind err_count.
module gga_field_parser #(
  parameter int TIME_DIGITS = 6,
  parameter int LAT_DIGITS  = 4,
  parameter int LON_DIGITS  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  gga_field_parser_if.slave        u,
  output logic [4*TIME_DIGITS-1:0] time_bcd,
  output logic [4*LAT_DIGITS-1:0]  lat_bcd,
  output logic                     lat_south,
  output logic [4*LON_DIGITS-1:0]  lon_bcd,
  output logic                     lon_west,
  output logic                     fix_valid,
  output logic                     parse_err,
  output logic [1:0]               err_code,
  output logic [7:0]               err_count
);

  localparam int MAXD = (TIME_DIGITS > LAT_DIGITS) ?
                        ((TIME_DIGITS > LON_DIGITS) ? TIME_DIGITS : LON_DIGITS) :
                        ((LAT_DIGITS  > LON_DIGITS) ? LAT_DIGITS  : LON_DIGITS);
  localparam int CW = $clog2(MAXD + 1);

  localparam logic [1:0] E_ILL = 2'd1;
  localparam logic [1:0] E_OVF = 2'd2;
  localparam logic [1:0] E_FLD = 2'd3;

  typedef enum logic [2:0] {IDLE, HDR, TIME, LAT, LAT_H, LAT_HC, LON, LON_H} state_t;

  state_t                  r_state;
  logic [2:0]              r_idx;
  logic [CW-1:0]           r_cnt;
  logic                    r_frac;
  logic [4*TIME_DIGITS-1:0] r_time_sh;
  logic [4*LAT_DIGITS-1:0]  r_lat_sh;
  logic [4*LON_DIGITS-1:0]  r_lon_sh;
  logic                    r_south_sh;

  logic [7:0]    w_byte;
  logic          w_is_dig;
  logic          w_dollar;
  logic [7:0]    w_hdr_ch;
  logic [CW-1:0] w_cap;
  logic          w_err;
  logic [1:0]    w_code;

  assign w_byte   = u.uart_data;
  assign w_is_dig = (w_byte >= "0") && (w_byte <= "9");
  assign w_dollar = (w_byte == "$");

  always_comb begin
    case (r_idx)
      3'd0:    w_hdr_ch = "G";
      3'd1:    w_hdr_ch = "P";
      3'd2:    w_hdr_ch = "G";
      3'd3:    w_hdr_ch = "G";
      3'd4:    w_hdr_ch = "A";
      default: w_hdr_ch = ",";
    endcase
  end

  // Abort detection; '$' always wins since it restarts rather than errors.
  always_comb begin
    w_cap  = '0;
    w_err  = 1'b0;
    w_code = 2'd0;
    case (r_state)
      TIME:    w_cap = CW'(TIME_DIGITS);
      LAT:     w_cap = CW'(LAT_DIGITS);
      LON:     w_cap = CW'(LON_DIGITS);
      default: w_cap = '0;
    endcase
    if (u.uart_valid && !w_dollar) begin
      case (r_state)
        TIME, LAT, LON: begin
          if (w_is_dig) begin
            if (!r_frac && r_cnt == w_cap) begin w_err = 1'b1; w_code = E_OVF; end
          end else if (w_byte == ".") begin
            if (r_frac) begin w_err = 1'b1; w_code = E_ILL; end
          end else if (w_byte == ",") begin
            if (r_cnt == '0) begin w_err = 1'b1; w_code = E_FLD; end
          end else begin
            w_err = 1'b1; w_code = E_ILL;
          end
        end
        LAT_H:  if (w_byte != "N" && w_byte != "S") begin w_err = 1'b1; w_code = E_FLD; end
        LAT_HC: if (w_byte != ",") begin w_err = 1'b1; w_code = E_ILL; end
        LON_H:  if (w_byte != "E" && w_byte != "W") begin w_err = 1'b1; w_code = E_FLD; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_frac     <= 1'b0;
      r_time_sh  <= '0;
      r_lat_sh   <= '0;
      r_lon_sh   <= '0;
      r_south_sh <= 1'b0;
      time_bcd   <= '0;
      lat_bcd    <= '0;
      lat_south  <= 1'b0;
      lon_bcd    <= '0;
      lon_west   <= 1'b0;
      fix_valid  <= 1'b0;
      parse_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      fix_valid <= 1'b0;
      parse_err <= 1'b0;
      if (u.uart_valid) begin
        if (w_dollar) begin
          r_state    <= HDR;
          r_idx      <= '0;
          r_cnt      <= '0;
          r_frac     <= 1'b0;
          r_time_sh  <= '0;
          r_lat_sh   <= '0;
          r_lon_sh   <= '0;
          r_south_sh <= 1'b0;
        end else if (w_err) begin
          r_state   <= IDLE;
          parse_err <= 1'b1;
          err_code  <= w_code;
        end else begin
          case (r_state)
            HDR: begin
              if (w_byte != w_hdr_ch) r_state <= IDLE;
              else if (r_idx == 3'd5) r_state <= TIME;
              else r_idx <= r_idx + 3'd1;
            end
            TIME, LAT, LON: begin
              if (w_is_dig) begin
                // Fractional digits are consumed but never stored.
                if (!r_frac) begin
                  r_cnt <= r_cnt + CW'(1);
                  case (r_state)
                    TIME:    r_time_sh <= {r_time_sh[4*TIME_DIGITS-5:0], w_byte[3:0]};
                    LAT:     r_lat_sh  <= {r_lat_sh[4*LAT_DIGITS-5:0], w_byte[3:0]};
                    default: r_lon_sh  <= {r_lon_sh[4*LON_DIGITS-5:0], w_byte[3:0]};
                  endcase
                end
              end else if (w_byte == ".") begin
                r_frac <= 1'b1;
              end else begin
                r_cnt  <= '0;
                r_frac <= 1'b0;
                case (r_state)
                  TIME:    r_state <= LAT;
                  LAT:     r_state <= LAT_H;
                  default: r_state <= LON_H;
                endcase
              end
            end
            LAT_H: begin
              r_south_sh <= (w_byte == "S");
              r_state    <= LAT_HC;
            end
            LAT_HC: r_state <= LON;
            LON_H: begin
              time_bcd  <= r_time_sh;
              lat_bcd   <= r_lat_sh;
              lat_south <= r_south_sh;
              lon_bcd   <= r_lon_sh;
              lon_west  <= (w_byte == "W");
              fix_valid <= 1'b1;
              r_state   <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef GGA_ERR_COUNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_err_cnt <= 8'h00;
    else if (parse_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
  end
  assign err_count = r_err_cnt;
`else
  assign err_count = 8'h00;
`endif

endmodule
